game_round_scheduler: RTL and testbench
=======================================

Name: game_round_scheduler

Overview:
Sequences the fire/gold dodging game and produces every game-status input the VGA display controller consumes: game_state, fire_state, gold_state, next_fire_pattern, hit_bitmap, life, score and win. It runs rounds of a WARN phase (next pattern previewed) and a BURN phase (fires live). It scores player overlap against fires and gold, and ends the game on win or loss. It sits between the player-position logic (box) and the display controller.

Parameters:
TICK_DIV, 1_000_000, clk cycles per game tick
ROUND_TICKS, 3, ticks per WARN phase and per BURN phase
LIFE_MAX, 5, starting lives (fits 3 bits)
SCORE_MAX, 3, score that wins the game
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  single-cycle start/restart pulse
box  in  9  player CT occupancy bitmap, row-major box index 0..8
game_state  out  2  INIT=00, PLAY=01, FINISH=10
fire_state  out  9  live fire boxes
gold_state  out  9  live gold box, one-hot or zero
next_fire_pattern  out  9  preview of the next BURN pattern
hit_bitmap  out  9  registered box & fire_state during BURN, else 0
life  out  3  remaining lives
score  out  4  gold collected
win  out  1  valid in FINISH; 1 = win, 0 = loss
round_done  out  1  one-cycle pulse at each BURN end

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- Reset values:
  - game_state = INIT.
  - fire_state, gold_state, next_fire_pattern, hit_bitmap = 0.
  - life = LIFE_MAX, score = 0, win = 0, round_done = 0.
  - LFSR = LFSR_SEED. Tick counter and phase counter = 0.
  - rst mid-game returns to these values immediately.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11. Advances every cycle in every state.
- Pattern generation (computed from the LFSR value in the cycle it is loaded):
  - pat = L[8:0] & L[15:7].
  - If pat == 0, pat = one-hot(L[3:0] mod 9).
- Gold generation:
  - g = L[7:4] mod 9.
  - gold = one-hot(g) & ~pat, so it can be zero.
- Tick and phase timing:
  - Tick counter counts 0..TICK_DIV-1 and cleared at each phase start.
  - Each phase lasts exactly ROUND_TICKS*TICK_DIV cycles.
- Internal phase FSM: IDLE, WARN, BURN, DONE. These map to game_state INIT, PLAY, PLAY, FINISH.
- IDLE:
  - On start: next_fire_pattern <= pat, go to WARN.
  - life = LIFE_MAX, score = 0, win = 0.
- WARN:
  - fire_state = 0, gold_state = 0, hit_bitmap = 0.
  - On phase end: fire_state <= next_fire_pattern, gold_state <= gold computed against that pattern, next_fire_pattern <= new pat, go to BURN.
- BURN, every cycle:
  - hit_bitmap <= box & fire_state, with one cycle latency.
  - Sticky hit_flag set if (box & fire_state) != 0.
  - Sticky gold_flag set if (box & gold_state) != 0; gold_state clears to 0 on the following cycle.
- BURN phase end (single evaluation, round_done pulses):
  - life_n = life - hit_flag, floored at 0.
  - score_n = score + gold_flag, saturating at SCORE_MAX.
  - If life_n == 0: go to DONE, win <= 0. Loss has priority over a simultaneous win.
  - Else if score_n == SCORE_MAX: go to DONE, win <= 1.
  - Else go to WARN.
  - Clear both flags, fire_state, gold_state and hit_bitmap.
- DONE:
  - All bitmaps are 0; life, score and win hold.
  - start goes to IDLE with life, score and win reinitialised. It does not auto-start.
- start is ignored in WARN and BURN.
- box changes take effect in the next cycle. Overlap lasting one cycle counts.
- All outputs are registered.

Decomposition:
- Shared package: game-state encodings INIT/PLAY/FINISH (used by the display controller too), LIFE_MAX, SCORE_MAX, and the box index helper constant 9.
- Sub-module pattern_lfsr: LFSR plus the pat and gold combinational derivation. Outputs pat[8:0] and gold_idx[3:0].
- The scheduler FSM, timers and scoring stay in game_round_scheduler.

Test Plan:
1. Reset then idle. Bench parameters for all scenarios: TICK_DIV=4, ROUND_TICKS=2.
   - Stimulus: 100 cycles, no start.
   - Required: game_state=00, life=5, score=0, all bitmaps 0, round_done never pulses.
2. Phase timing.
   - Stimulus: start pulse, box=0.
   - Required: fire_state becomes non-zero exactly 8 cycles after WARN entry. round_done pulses 8 cycles later. fire_state equals the next_fire_pattern value seen during WARN. life stays 5.
3. Hit.
   - Stimulus: during BURN, drive box = fire_state bit for 1 cycle.
   - Required: hit_bitmap equals that bit on the next cycle. life drops 5->4 at round_done, only once even if overlap repeats.
4. Gold.
   - Stimulus: drive box = gold_state during BURN.
   - Required: gold_state goes to 0 on the next cycle. score goes 0->1 at round_done.
   - After 3 collections: game_state=10, win=1.
5. Loss and simultaneous events.
   - Stimulus: life=1 and score=2, then collect gold and hit fire in the same BURN.
   - Required: FINISH with win=0, life=0, score=3.
6. Restart and reset.
   - Stimulus: start in FINISH.
   - Required: INIT with life=5, score=0, win=0.
   - Stimulus: assert rst mid-BURN.
   - Required: all outputs return to reset values without waiting for a clk edge.

Source files
------------

// File: rtl/game_round_scheduler_pkg.sv
// Shared definitions for the fire/gold dodging game.
//   game_state_e : game-state encoding also decoded by the display controller
//   phase_e      : internal round-phase states of the scheduler
//   LIFE_MAX, SCORE_MAX, NUM_BOXES : game constants
//   mod9, box_onehot : box-index helpers
package game_round_scheduler_pkg;

  typedef enum logic [1:0] {
    GS_INIT   = 2'b00,
    GS_PLAY   = 2'b01,
    GS_FINISH = 2'b10
  } game_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_WARN,
    PH_BURN,
    PH_DONE
  } phase_e;

  localparam int unsigned LIFE_MAX  = 5;
  localparam int unsigned SCORE_MAX = 3;
  localparam int unsigned NUM_BOXES = 9;

  function automatic logic [3:0] mod9(input logic [3:0] v);
    return (v >= 4'd9) ? (v - 4'd9) : v;
  endfunction

  function automatic logic [NUM_BOXES-1:0] box_onehot(input logic [3:0] idx);
    return NUM_BOXES'(1) << idx;
  endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) with the combinational
// fire-pattern and gold-index derivation.
//   clk, rst : clock, asynchronous active-high reset (LFSR <= LFSR_SEED)
//   pat      : fire pattern derived from the current LFSR value, never zero
//   gold_idx : gold box index 0..8 derived from the current LFSR value
module pattern_lfsr
  import game_round_scheduler_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [8:0] pat,
  output logic [3:0] gold_idx
);

  logic [15:0] lfsr_q, lfsr_d;
  logic [8:0]  raw_pat;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  // An all-zero AND falls back to a single fire so every BURN has a hazard.
  always_comb begin
    raw_pat  = lfsr_q[8:0] & lfsr_q[15:7];
    pat      = (raw_pat == '0) ? box_onehot(mod9(lfsr_q[3:0])) : raw_pat;
    gold_idx = mod9(lfsr_q[7:4]);
  end

endmodule

// File: rtl/game_round_scheduler.sv
// Round scheduler for the fire/gold dodging game: WARN phase previews the
// next pattern, BURN phase makes fires live and scores player overlap.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : single-cycle start/restart pulse
//   box               : player occupancy bitmap, row-major index 0..8
//   game_state        : INIT/PLAY/FINISH for the display controller
//   fire_state        : live fire boxes (BURN only)
//   gold_state        : live gold box, one-hot or zero (BURN only)
//   next_fire_pattern : preview of the next BURN pattern
//   hit_bitmap        : registered box & fire_state during BURN
//   life, score, win  : remaining lives, gold collected, FINISH outcome
//   round_done        : one-cycle pulse after each BURN end
module game_round_scheduler #(
  parameter int unsigned TICK_DIV    = 1_000_000,
  parameter int unsigned ROUND_TICKS = 3,
  parameter int unsigned LIFE_MAX    = game_round_scheduler_pkg::LIFE_MAX,
  parameter int unsigned SCORE_MAX   = game_round_scheduler_pkg::SCORE_MAX,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] box,
  output logic [1:0] game_state,
  output logic [8:0] fire_state,
  output logic [8:0] gold_state,
  output logic [8:0] next_fire_pattern,
  output logic [8:0] hit_bitmap,
  output logic [2:0] life,
  output logic [3:0] score,
  output logic       win,
  output logic       round_done
);

  import game_round_scheduler_pkg::*;

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW = (ROUND_TICKS > 1) ? $clog2(ROUND_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(ROUND_TICKS - 1);
  localparam logic [2:0]    LIFE_INIT  = 3'(LIFE_MAX);
  localparam logic [3:0]    SCORE_WIN  = 4'(SCORE_MAX);

  phase_e      state_q, state_d;
  game_state_e game_state_q, game_state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [8:0]  fire_q, fire_d, gold_q, gold_d, next_q, next_d, hit_q, hit_d;
  logic [2:0]  life_q, life_d, life_n;
  logic [3:0]  score_q, score_d, score_n;
  logic        win_q, win_d, round_done_q, round_done_d;
  logic        hit_flag_q, hit_flag_d, gold_flag_q, gold_flag_d;
  logic        phase_end, hit_now, gold_now;
  logic [8:0]  box_fire, box_gold, pat, new_gold;
  logic [3:0]  gold_idx;

  pattern_lfsr #(
    .LFSR_SEED (LFSR_SEED)
  ) u_pattern_lfsr (
    .clk      (clk),
    .rst      (rst),
    .pat      (pat),
    .gold_idx (gold_idx)
  );

  assign phase_end = (tick_q == TICK_LAST) && (phase_q == PHASE_LAST);

  // Counters run only in WARN/BURN and are zero on entry to each phase.
  always_comb begin
    tick_d  = '0;
    phase_d = '0;
    if (state_q == PH_WARN || state_q == PH_BURN) begin
      if (tick_q == TICK_LAST) begin
        tick_d  = '0;
        phase_d = phase_end ? '0 : phase_q + 1'b1;
      end else begin
        tick_d  = tick_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  // The final BURN cycle still counts its own overlap, so the end-of-round
  // decision folds the live overlap into the sticky flags.
  always_comb begin
    box_fire = box & fire_q;
    box_gold = box & gold_q;
    hit_now  = hit_flag_q | (|box_fire);
    gold_now = gold_flag_q | (|box_gold);
    life_n   = (hit_now && life_q != '0) ? life_q - 3'd1 : life_q;
    score_n  = (gold_now && score_q < SCORE_WIN) ? score_q + 4'd1 : score_q;
    new_gold = box_onehot(gold_idx) & ~next_q;
  end

  always_comb begin
    state_d      = state_q;
    fire_d       = fire_q;
    gold_d       = gold_q;
    next_d       = next_q;
    hit_d        = hit_q;
    life_d       = life_q;
    score_d      = score_q;
    win_d        = win_q;
    round_done_d = 1'b0;
    hit_flag_d   = hit_flag_q;
    gold_flag_d  = gold_flag_q;

    unique case (state_q)
      PH_IDLE: begin
        fire_d  = '0;
        gold_d  = '0;
        hit_d   = '0;
        life_d  = LIFE_INIT;
        score_d = '0;
        win_d   = 1'b0;
        if (start) begin
          next_d  = pat;
          state_d = PH_WARN;
        end
      end
      PH_WARN: begin
        fire_d = '0;
        gold_d = '0;
        hit_d  = '0;
        if (phase_end) begin
          fire_d  = next_q;
          gold_d  = new_gold;
          next_d  = pat;
          state_d = PH_BURN;
        end
      end
      PH_BURN: begin
        hit_d       = box_fire;
        hit_flag_d  = hit_now;
        gold_flag_d = gold_now;
        if (|box_gold) gold_d = '0;
        if (phase_end) begin
          round_done_d = 1'b1;
          life_d       = life_n;
          score_d      = score_n;
          hit_flag_d   = 1'b0;
          gold_flag_d  = 1'b0;
          fire_d       = '0;
          gold_d       = '0;
          hit_d        = '0;
          if (life_n == '0) begin
            win_d   = 1'b0;
            next_d  = '0;
            state_d = PH_DONE;
          end else if (score_n == SCORE_WIN) begin
            win_d   = 1'b1;
            next_d  = '0;
            state_d = PH_DONE;
          end else begin
            state_d = PH_WARN;
          end
        end
      end
      PH_DONE: begin
        fire_d = '0;
        gold_d = '0;
        hit_d  = '0;
        next_d = '0;
        if (start) begin
          life_d  = LIFE_INIT;
          score_d = '0;
          win_d   = 1'b0;
          state_d = PH_IDLE;
        end
      end
      default: state_d = PH_IDLE;
    endcase
  end

  always_comb begin
    game_state_d = GS_INIT;
    unique case (state_d)
      PH_IDLE:          game_state_d = GS_INIT;
      PH_WARN, PH_BURN: game_state_d = GS_PLAY;
      PH_DONE:          game_state_d = GS_FINISH;
      default:          game_state_d = GS_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PH_IDLE;
      game_state_q <= GS_INIT;
      tick_q       <= '0;
      phase_q      <= '0;
      fire_q       <= '0;
      gold_q       <= '0;
      next_q       <= '0;
      hit_q        <= '0;
      life_q       <= LIFE_INIT;
      score_q      <= '0;
      win_q        <= 1'b0;
      round_done_q <= 1'b0;
      hit_flag_q   <= 1'b0;
      gold_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      game_state_q <= game_state_d;
      tick_q       <= tick_d;
      phase_q      <= phase_d;
      fire_q       <= fire_d;
      gold_q       <= gold_d;
      next_q       <= next_d;
      hit_q        <= hit_d;
      life_q       <= life_d;
      score_q      <= score_d;
      win_q        <= win_d;
      round_done_q <= round_done_d;
      hit_flag_q   <= hit_flag_d;
      gold_flag_q  <= gold_flag_d;
    end
  end

  assign game_state        = game_state_q;
  assign fire_state        = fire_q;
  assign gold_state        = gold_q;
  assign next_fire_pattern = next_q;
  assign hit_bitmap        = hit_q;
  assign life              = life_q;
  assign score             = score_q;
  assign win               = win_q;
  assign round_done        = round_done_q;

endmodule

// File: tb/tb_game_round_scheduler.sv
module tb_game_round_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] box = '0;
  logic [1:0] game_state;
  logic [8:0] fire_state, gold_state, next_fire_pattern, hit_bitmap;
  logic [2:0] life;
  logic [3:0] score;
  logic       win, round_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_l;
  logic [8:0]  exp_next;
  int          life_exp, score_exp;
  bit          game_over, win_exp;

  game_round_scheduler #(
    .TICK_DIV    (4),
    .ROUND_TICKS (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .box               (box),
    .game_state        (game_state),
    .fire_state        (fire_state),
    .gold_state        (gold_state),
    .next_fire_pattern (next_fire_pattern),
    .hit_bitmap        (hit_bitmap),
    .life              (life),
    .score             (score),
    .win               (win),
    .round_done        (round_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  function automatic logic [8:0] pat_of(input logic [15:0] l);
    logic [8:0] p;
    p = l[8:0] & l[15:7];
    if (p == 9'd0) p = 9'd1 << (int'(l[3:0]) % 9);
    return p;
  endfunction

  function automatic logic [8:0] gold_of(input logic [15:0] l, input logic [8:0] p);
    return (9'd1 << (int'(l[7:4]) % 9)) & ~p;
  endfunction

  // Reference LFSR, stepping in lockstep with the design from the same seed.
  always @(posedge clk or posedge rst) begin
    if (rst) m_l <= 16'hACE1;
    else     m_l <= lfsr_step(m_l);
  end

  task automatic pulse_start(input bit from_idle);
    @(negedge clk);
    start = 1'b1;
    if (from_idle) exp_next = pat_of(m_l);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge of WARN cycle 0; leaves at the negedge one cycle
  // after the BURN end edge (next WARN cycle 0 or FINISH).
  task automatic run_round(input bit do_hit, input bit want_gold, input bit final_mode,
                           input string tag);
    logic [8:0] efire, egold, hitbit, bx;
    bit dh, took;
    n_checks++;
    if (game_state !== 2'b01) begin
      n_fail++; $display("FAIL %s warn_state: got %b want 01", tag, game_state);
    end
    n_checks++;
    if (next_fire_pattern !== exp_next) begin
      n_fail++; $display("FAIL %s warn_preview: got %h want %h", tag, next_fire_pattern, exp_next);
    end
    repeat (7) @(negedge clk);
    n_checks++;
    if (fire_state !== 9'd0 || gold_state !== 9'd0 || round_done !== 1'b0) begin
      n_fail++; $display("FAIL %s warn_quiet: fire %h gold %h rd %b want 0 0 0", tag, fire_state, gold_state, round_done);
    end
    efire    = exp_next;
    egold    = gold_of(m_l, exp_next);
    exp_next = pat_of(m_l);
    @(negedge clk);
    n_checks++;
    if (fire_state !== efire || gold_state !== egold || next_fire_pattern !== exp_next) begin
      n_fail++; $display("FAIL %s burn_load: fire %h gold %h next %h want %h %h %h", tag,
                         fire_state, gold_state, next_fire_pattern, efire, egold, exp_next);
    end
    dh = do_hit;
    if (final_mode && egold == 9'd0) dh = 1'b0;
    took   = want_gold && (egold != 9'd0);
    hitbit = efire & (~efire + 9'd1);
    bx     = dh ? hitbit : 9'd0;
    if (took) bx = bx | egold;
    box = bx;
    @(negedge clk);
    box = '0;
    n_checks++;
    if (hit_bitmap !== (bx & efire)) begin
      n_fail++; $display("FAIL %s hit_bitmap: got %h want %h", tag, hit_bitmap, bx & efire);
    end
    n_checks++;
    if (gold_state !== (took ? 9'd0 : egold)) begin
      n_fail++; $display("FAIL %s gold_clear: got %h want %h", tag, gold_state, took ? 9'd0 : egold);
    end
    @(negedge clk);
    n_checks++;
    if (hit_bitmap !== 9'd0) begin
      n_fail++; $display("FAIL %s hit_release: got %h want 0", tag, hit_bitmap);
    end
    box = dh ? hitbit : 9'd0;
    @(negedge clk);
    box = '0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (round_done !== 1'b0 || life !== 3'(life_exp)) begin
      n_fail++; $display("FAIL %s pre_end: rd %b life %0d want 0 %0d", tag, round_done, life, life_exp);
    end
    if (dh && life_exp > 0) life_exp--;
    if (took && score_exp < 3) score_exp++;
    if (life_exp == 0) begin
      game_over = 1'b1; win_exp = 1'b0;
    end else if (score_exp == 3) begin
      game_over = 1'b1; win_exp = 1'b1;
    end
    if (game_over) exp_next = 9'd0;
    @(negedge clk);
    n_checks++;
    if (round_done !== 1'b1) begin
      n_fail++; $display("FAIL %s round_done: got %b want 1", tag, round_done);
    end
    n_checks++;
    if (life !== 3'(life_exp) || score !== 4'(score_exp)) begin
      n_fail++; $display("FAIL %s score_life: life %0d score %0d want %0d %0d", tag, life, score, life_exp, score_exp);
    end
    n_checks++;
    if (fire_state !== 9'd0 || gold_state !== 9'd0 || hit_bitmap !== 9'd0) begin
      n_fail++; $display("FAIL %s end_clear: fire %h gold %h hit %h want 0", tag, fire_state, gold_state, hit_bitmap);
    end
    n_checks++;
    if (game_state !== (game_over ? 2'b10 : 2'b01)) begin
      n_fail++; $display("FAIL %s end_state: got %b want %b", tag, game_state, game_over ? 2'b10 : 2'b01);
    end
    if (game_over) begin
      n_checks++;
      if (win !== win_exp || next_fire_pattern !== 9'd0) begin
        n_fail++; $display("FAIL %s finish: win %b next %h want %b 0", tag, win, next_fire_pattern, win_exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if (game_state !== 2'b00 || life !== 3'd5 || score !== 4'd0 || win !== 1'b0 ||
          fire_state !== 9'd0 || gold_state !== 9'd0 || next_fire_pattern !== 9'd0 ||
          hit_bitmap !== 9'd0 || round_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: gs %b life %0d score %0d win %b fire %h gold %h next %h hit %h rd %b want 00 5 0 0 0 0 0 0 0",
                 i, game_state, life, score, win, fire_state, gold_state, next_fire_pattern, hit_bitmap, round_done);
      end
    end
    life_exp = 5; score_exp = 0; game_over = 1'b0; win_exp = 1'b0; exp_next = 9'd0;
  endtask

  task automatic test_phase_timing();
    pulse_start(1'b1);
    run_round(1'b0, 1'b0, 1'b0, "timing");
  endtask

  task automatic test_hit();
    run_round(1'b1, 1'b0, 1'b0, "hit");
  endtask

  task automatic test_gold();
    for (int r = 0; r < 15 && !game_over; r++) run_round(1'b0, 1'b1, 1'b0, "gold");
    n_checks++;
    if (game_state !== 2'b10 || win !== 1'b1 || score !== 4'd3) begin
      n_fail++; $display("FAIL gold_win: gs %b win %b score %0d want 10 1 3", game_state, win, score);
    end
  endtask

  task automatic test_restart();
    pulse_start(1'b0);
    n_checks++;
    if (game_state !== 2'b00 || life !== 3'd5 || score !== 4'd0 || win !== 1'b0 || next_fire_pattern !== 9'd0) begin
      n_fail++; $display("FAIL restart: gs %b life %0d score %0d win %b next %h want 00 5 0 0 0",
                         game_state, life, score, win, next_fire_pattern);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (game_state !== 2'b00) begin
      n_fail++; $display("FAIL no_autostart: got %b want 00", game_state);
    end
    life_exp = 5; score_exp = 0; game_over = 1'b0; win_exp = 1'b0; exp_next = 9'd0;
  endtask

  task automatic test_loss();
    pulse_start(1'b1);
    for (int r = 0; r < 30 && !game_over; r++) begin
      if (life_exp == 1 && score_exp == 2) run_round(1'b1, 1'b1, 1'b1, "loss_final");
      else run_round(life_exp > 1, score_exp < 2, 1'b0, "loss_setup");
    end
    n_checks++;
    if (game_state !== 2'b10 || win !== 1'b0 || life !== 3'd0 || score !== 4'd3) begin
      n_fail++; $display("FAIL loss_priority: gs %b win %b life %0d score %0d want 10 0 0 3",
                         game_state, win, life, score);
    end
  endtask

  task automatic test_async_reset();
    pulse_start(1'b0);
    pulse_start(1'b1);
    repeat (10) @(negedge clk);
    box = '1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (game_state !== 2'b00 || life !== 3'd5 || score !== 4'd0 || win !== 1'b0 ||
        fire_state !== 9'd0 || gold_state !== 9'd0 || next_fire_pattern !== 9'd0 ||
        hit_bitmap !== 9'd0 || round_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: gs %b life %0d score %0d win %b fire %h gold %h next %h hit %h rd %b want 00 5 0 0 0 0 0 0 0",
               game_state, life, score, win, fire_state, gold_state, next_fire_pattern, hit_bitmap, round_done);
    end
    @(negedge clk);
    rst = 1'b0;
    box = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (game_state !== 2'b00 || life !== 3'd5) begin
      n_fail++; $display("FAIL post_reset_idle: gs %b life %0d want 00 5", game_state, life);
    end
  endtask

  initial begin
    test_reset();
    test_phase_timing();
    test_hit();
    test_gold();
    test_restart();
    test_loss();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
